// File: rtl/mul_1_if.sv
// Operand/product bundle for the mul_1 pipelined multiplier.
// The master drives operands; the slave (the multiplier) returns the product.
interface mul_1_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic [2*WIDTH-1:0]   out;

  modport master (output in_valid, output a, output b, input out_valid, input out);
  modport slave  (input in_valid, input a, input b, output out_valid, output out);
endinterface

// File: rtl/mul_1.sv
// Three-stage pipelined multiplier, full 2*WIDTH product, one pair per clock.
// Define MUL1_SIGNED_EN for two's-complement operands; otherwise unsigned.
module mul_1 #(
  parameter int WIDTH = 16
) (
  input logic   clk,
  input logic   rst_n,
  mul_1_if.slave bus
);
  localparam int PW   = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;
`ifdef MUL1_SIGNED_EN
  localparam bit SIGNED_MUL = 1'b1;
`else
  localparam bit SIGNED_MUL = 1'b0;
`endif

  logic [WIDTH-1:0] a_s1;
  logic [WIDTH-1:0] b_s1;
  logic             valid_s1;
  logic [PW-1:0]    sum_lo;
  logic [PW-1:0]    sum_hi;
  logic             valid_s2;
  logic [PW-1:0]    prod;
  logic             valid_s3;

  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    sum_lo_d;
  logic [PW-1:0]    sum_hi_d;

  assign a_ext = SIGNED_MUL ? {{WIDTH{a_s1[WIDTH-1]}}, a_s1} : {{WIDTH{1'b0}}, a_s1};

  // The MSB row carries weight -2^(WIDTH-1) for signed operands, so it is subtracted.
  always_comb begin
    sum_lo_d = '0;
    sum_hi_d = '0;
    pp       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp = b_s1[i] ? (a_ext << i) : '0;
      if (i < HALF)
        sum_lo_d = sum_lo_d + pp;
      else if (SIGNED_MUL && (i == WIDTH - 1))
        sum_hi_d = sum_hi_d - pp;
      else
        sum_hi_d = sum_hi_d + pp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1     <= '0;
      b_s1     <= '0;
      valid_s1 <= 1'b0;
      sum_lo   <= '0;
      sum_hi   <= '0;
      valid_s2 <= 1'b0;
      prod     <= '0;
      valid_s3 <= 1'b0;
    end else begin
      valid_s1 <= bus.in_valid;
      valid_s2 <= valid_s1;
      valid_s3 <= valid_s2;
      if (bus.in_valid) begin
        a_s1 <= bus.a;
        b_s1 <= bus.b;
      end
      if (valid_s1) begin
        sum_lo <= sum_lo_d;
        sum_hi <= sum_hi_d;
      end
      if (valid_s2)
        prod <= sum_lo + sum_hi;
    end
  end

  assign bus.out       = prod;
  assign bus.out_valid = valid_s3;
endmodule

// File: tb/tb_mul_1.sv
// Scoreboard bench for mul_1: expected products queued at drive time, popped on out_valid.
// Honours MUL1_SIGNED_EN to select the signed reference model.
module tb_mul_1;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [2*W-1:0] exp_q[$];

  mul_1_if #(.WIDTH(W)) bus ();

  mul_1 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx;
    logic signed [2*W-1:0] sy;
    logic signed [2*W-1:0] sp;
`ifdef MUL1_SIGNED_EN
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
`else
    sx = {{W{1'b0}}, x};
    sy = {{W{1'b0}}, y};
`endif
    sp = sx * sy;
    return sp;
  endfunction

  // Drives one cycle of stimulus starting just after a rising edge.
  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
    if (v) exp_q.push_back(model(x, y));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_and_check(input string tag, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [2*W-1:0] expv);
    drive(1'b1, x, y);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    check(tag, {32'd0, bus.out}, {32'd0, expv});
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() > 0)
        check("sb_prod", {32'd0, bus.out}, {32'd0, exp_q.pop_front()});
      else
        check("sb_spurious", 64'd1, 64'd0);
    end
  end

  initial begin
    logic [2*W-1:0] ffff_exp;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef MUL1_SIGNED_EN
    ffff_exp = 32'h0000_0001;
`else
    ffff_exp = 32'hFFFE_0001;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {32'd0, bus.out}, 64'd0);
    check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic latency and single-cycle pulse
    drive(1'b1, 16'd3, 16'd2);
    @(posedge clk); #1;
    check("lat_early", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;
    check("lat_valid", {63'd0, bus.out_valid}, 64'd1);
    check("lat_prod", {32'd0, bus.out}, 64'd6);
    @(posedge clk); #1;
    check("pulse_end", {63'd0, bus.out_valid}, 64'd0);
    check("hold_6", {32'd0, bus.out}, 64'd6);

    // back-to-back
    drive(1'b1, 16'd10, 16'd5);
    drive(1'b1, 16'd255, 16'd255);
    @(posedge clk); #1;
    check("b2b_0", {32'd0, bus.out}, 64'd50);
    check("b2b_0_valid", {63'd0, bus.out_valid}, 64'd1);
    @(posedge clk); #1;
    check("b2b_1", {32'd0, bus.out}, 64'd65025);
    check("b2b_1_valid", {63'd0, bus.out_valid}, 64'd1);
    repeat (2) @(posedge clk); #1;

    drive_and_check("max_max", 16'hFFFF, 16'hFFFF, ffff_exp);
    drive_and_check("min_min", 16'h8000, 16'h8000, 32'h4000_0000);
    drive_and_check("zero_x", 16'h0000, 16'h1234, 32'd0);

    // idle data is ignored
    drive(1'b0, 16'd7, 16'd7);
    drive(1'b0, 16'd7, 16'd7);
    drive(1'b0, 16'd7, 16'd7);
    check("idle_hold", {32'd0, bus.out}, 64'd0);
    check("idle_valid", {63'd0, bus.out_valid}, 64'd0);

    // reset mid-flight
    drive(1'b1, 16'd100, 16'd3);
    drive(1'b1, 16'd9, 16'd9);
    drive(1'b1, 16'd4, 16'd4);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out", {32'd0, bus.out}, 64'd0);
    check("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("post_rst_quiet", {63'd0, bus.out_valid}, 64'd0);
    end
    drive_and_check("post_rst_first", 16'd12, 16'd11, 32'd132);

    // random valid/idle mix
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++)
      @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
